// File: rtl/load_store_unit.sv
// Load/store unit: memory-access stage behind the ALU. Runs one data-memory
// transaction per request over a req/gnt/rvalid bus, steers store bytes onto
// their lanes, extends load data and returns a one-cycle response to writeback.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 255  // WAIT cycles before bus_err; 0 disables
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [4:0]  rd,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        resp_valid,
  output logic [4:0]  resp_rd,
  output logic [31:0] resp_rdata,
  output logic        misaligned,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  // The counter only has to reach TIMEOUT-1, so size it for that value.
  localparam int unsigned   CW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state, state_next;
  logic          accept;
  logic          bad_op;
  logic          timeout_hit;
  logic [3:0]    be_next;
  logic [31:0]   wdata_next;
  logic [31:0]   lane;
  logic [31:0]   load_ext;

  // Captured request and response fields
  logic [3:0]    op_q;
  logic [1:0]    lane_q;
  logic [4:0]    rd_q;
  logic [CW-1:0] cnt;
  logic [31:0]   rdata_q;
  logic          mis_q;
  logic          err_q;

  assign accept      = req_valid && (state == IDLE);
  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

  // Decode the incoming op: legality, alignment, byte enables and lane replication
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    bad_op     = 1'b0;
    be_next    = 4'b1111;
    wdata_next = wdata;
    case (mem_op[1:0])
      2'd0: begin
        be_next    = 4'b0001 << addr[1:0];
        wdata_next = {4{wdata[7:0]}};
      end
      2'd1: begin
        be_next    = 4'b0011 << addr[1:0];
        wdata_next = {2{wdata[15:0]}};
        bad_op     = addr[0];
      end
      2'd2:    bad_op = (addr[1:0] != 2'b00) || mem_op[2];
      default: bad_op = 1'b1;
    endcase
    // There is no "unsigned store"
    if (mem_op[3] && mem_op[2]) bad_op = 1'b1;
  end

  // Pick the addressed lane out of the read word and sign/zero-extend it
  always_comb begin
    lane     = dmem_rdata >> {lane_q, 3'b000};
    load_ext = lane;
    case (op_q[1:0])
      2'd0:    load_ext = {{24{~op_q[2] & lane[7]}},  lane[7:0]};
      2'd1:    load_ext = {{16{~op_q[2] & lane[15]}}, lane[15:0]};
      default: load_ext = lane;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge nrst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the edge, independent of statement order.
    if (!nrst) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept)                         state_next = bad_op ? RESP : REQ;
      REQ:  if (dmem_gnt)                       state_next = op_q[3] ? RESP : WAIT;
      WAIT: if (dmem_rvalid || timeout_hit)     state_next = RESP;
      RESP:                                     state_next = IDLE;
      default:                                  state_next = IDLE;
    endcase
  end

  // Request capture, bus fields, timeout counter and response data
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      op_q       <= '0;
      lane_q     <= '0;
      rd_q       <= '0;
      cnt        <= '0;
      rdata_q    <= '0;
      mis_q      <= 1'b0;
      err_q      <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_q    <= mem_op;
          lane_q  <= addr[1:0];
          rd_q    <= rd;
          rdata_q <= '0;
          mis_q   <= bad_op;
          err_q   <= 1'b0;
          // Bus fields only change for ops that will actually reach the bus
          if (!bad_op) begin
            dmem_we    <= mem_op[3];
            dmem_addr  <= {addr[31:2], 2'b00};
            dmem_be    <= be_next;
            dmem_wdata <= wdata_next;
          end
        end
        REQ: if (dmem_gnt) cnt <= '0;
        WAIT: begin
          if (dmem_rvalid)      rdata_q <= load_ext;
          else if (timeout_hit) err_q   <= 1'b1;
          else                  cnt     <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Handshake and response outputs, decoded from the registered state
  always_comb begin
    req_ready  = (state == IDLE);
    dmem_req   = (state == REQ);
    resp_valid = (state == RESP);
    resp_rd    = '0;
    resp_rdata = '0;
    misaligned = 1'b0;
    bus_err    = 1'b0;
    if (state == RESP) begin
      resp_rd    = op_q[3] ? 5'd0 : rd_q;
      resp_rdata = rdata_q;
      misaligned = mis_q;
      bus_err    = err_q;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: expected responses are queued when a
// request is issued and compared when resp_valid fires.
module tb_load_store_unit;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic        mis;
    logic        err;
  } resp_t;

  logic        clk;
  logic        nrst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  mem_op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [4:0]  rd;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        resp_valid;
  logic [4:0]  resp_rd;
  logic [31:0] resp_rdata;
  logic        misaligned;
  logic        bus_err;

  int    n_cmp = 0;
  int    n_bad = 0;
  resp_t sb[$];
  resp_t got_exp;

  load_store_unit #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .mem_op     (mem_op),
    .addr       (addr),
    .wdata      (wdata),
    .rd         (rd),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_be    (dmem_be),
    .dmem_wdata (dmem_wdata),
    .dmem_gnt   (dmem_gnt),
    .dmem_rvalid(dmem_rvalid),
    .dmem_rdata (dmem_rdata),
    .resp_valid (resp_valid),
    .resp_rd    (resp_rd),
    .resp_rdata (resp_rdata),
    .misaligned (misaligned),
    .bus_err    (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic resp_t mk(input logic [4:0] r, input logic [31:0] d,
                               input logic m, input logic e);
    resp_t x;
    x.rd = r; x.rdata = d; x.mis = m; x.err = e;
    return x;
  endfunction

  // Scoreboard: compare every response pulse with the oldest expectation
  always @(negedge clk) begin
    if (resp_valid) begin
      n_cmp++;
      assert (sb.size() != 0) else begin
        n_bad++;
        $error("FAIL resp_unexpected: observed response rd=%0d expected none", resp_rd);
      end
      if (sb.size() != 0) begin
        got_exp = sb.pop_front();
        check("resp_rd",    {27'd0, resp_rd},    {27'd0, got_exp.rd});
        check("resp_rdata", resp_rdata,          got_exp.rdata);
        check("misaligned", {31'd0, misaligned}, {31'd0, got_exp.mis});
        check("bus_err",    {31'd0, bus_err},    {31'd0, got_exp.err});
      end
    end
  end

  // Issue one op and play the memory side. gnt_dly = cycles dmem_req waits for
  // gnt; give_rv = return read data in the first WAIT cycle, else let it time out.
  task automatic do_op(input string name, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] r,
                       input logic [3:0] exp_be, input logic [31:0] exp_wd,
                       input int gnt_dly, input bit give_rv,
                       input logic [31:0] rword, input resp_t exp);
    sb.push_back(exp);
    req_valid = 1'b1; mem_op = op; addr = a; wdata = wd; rd = r;
    check({name, "/req_ready"}, {31'd0, req_ready}, 32'd1);
    step();
    req_valid = 1'b0;
    if (exp.mis) begin
      check({name, "/no_dmem_req"}, {31'd0, dmem_req},   32'd0);
      check({name, "/resp_t1"},     {31'd0, resp_valid}, 32'd1);
      step();
      return;
    end
    for (int i = 0; i <= gnt_dly; i++) begin
      check({name, "/dmem_req"},  {31'd0, dmem_req}, 32'd1);
      check({name, "/dmem_we"},   {31'd0, dmem_we},  {31'd0, op[3]});
      check({name, "/dmem_addr"}, dmem_addr,         {a[31:2], 2'b00});
      check({name, "/dmem_be"},   {28'd0, dmem_be},  {28'd0, exp_be});
      if (op[3]) check({name, "/dmem_wdata"}, dmem_wdata, exp_wd);
      if (i < gnt_dly) step();
    end
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    check({name, "/req_dropped"}, {31'd0, dmem_req}, 32'd0);
    if (op[3]) begin
      check({name, "/store_resp_t2"}, {31'd0, resp_valid}, 32'd1);
      step();
      return;
    end
    if (give_rv) begin
      dmem_rvalid = 1'b1; dmem_rdata = rword;
      step();
      dmem_rvalid = 1'b0; dmem_rdata = 32'h5A5A_5A5A;
      check({name, "/load_resp_t3"}, {31'd0, resp_valid}, 32'd1);
    end else begin
      for (int i = 0; i < 20 && !resp_valid; i++) step();
      check({name, "/timeout_resp"}, {31'd0, resp_valid}, 32'd1);
    end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nrst = 1'b0; req_valid = 1'b0; mem_op = '0; addr = '0; wdata = '0; rd = '0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    step(); step();

    // Reset state
    check("rst/req_ready",  {31'd0, req_ready},  32'd1);
    check("rst/dmem_req",   {31'd0, dmem_req},   32'd0);
    check("rst/dmem_be",    {28'd0, dmem_be},    32'd0);
    check("rst/dmem_addr",  dmem_addr,           32'd0);
    check("rst/resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst/resp_rdata", resp_rdata,          32'd0);
    nrst = 1'b1;
    step();

    // Stores
    do_op("sw", 4'b1010, 32'h100, 32'hDEAD_BEEF, 5'd3, 4'hF, 32'hDEAD_BEEF, 0, 1'b0, '0,
          mk(5'd0, 32'd0, 1'b0, 1'b0));
    do_op("sb", 4'b1000, 32'h103, 32'h0000_00A5, 5'd4, 4'b1000, 32'hA5A5_A5A5, 0, 1'b0, '0,
          mk(5'd0, 32'd0, 1'b0, 1'b0));
    do_op("sh", 4'b1001, 32'h102, 32'h1234_ABCD, 5'd4, 4'b1100, 32'hABCD_ABCD, 0, 1'b0, '0,
          mk(5'd0, 32'd0, 1'b0, 1'b0));

    // Loads with lane select and extension
    do_op("lb",  4'b0000, 32'h102, '0, 5'd5, 4'b0100, '0, 0, 1'b1, 32'h12F0_3456,
          mk(5'd5, 32'hFFFF_FFF0, 1'b0, 1'b0));
    do_op("lbu", 4'b0100, 32'h102, '0, 5'd6, 4'b0100, '0, 0, 1'b1, 32'h12F0_3456,
          mk(5'd6, 32'h0000_00F0, 1'b0, 1'b0));
    do_op("lh",  4'b0001, 32'h102, '0, 5'd7, 4'b1100, '0, 0, 1'b1, 32'h12F0_3456,
          mk(5'd7, 32'h0000_12F0, 1'b0, 1'b0));
    do_op("lh0", 4'b0001, 32'h100, '0, 5'd8, 4'b0011, '0, 0, 1'b1, 32'h0000_8001,
          mk(5'd8, 32'hFFFF_8001, 1'b0, 1'b0));
    do_op("lhu", 4'b0101, 32'h100, '0, 5'd8, 4'b0011, '0, 0, 1'b1, 32'h0000_8001,
          mk(5'd8, 32'h0000_8001, 1'b0, 1'b0));
    do_op("lw",  4'b0010, 32'h104, '0, 5'd9, 4'hF, '0, 0, 1'b1, 32'h89AB_CDEF,
          mk(5'd9, 32'h89AB_CDEF, 1'b0, 1'b0));

    // Misaligned and illegal ops never touch the bus
    do_op("lw_mis",  4'b0010, 32'h102, '0, 5'd10, '0, '0, 0, 1'b0, '0, mk(5'd10, 32'd0, 1'b1, 1'b0));
    do_op("size3",   4'b0011, 32'h100, '0, 5'd11, '0, '0, 0, 1'b0, '0, mk(5'd11, 32'd0, 1'b1, 1'b0));
    do_op("lh_mis",  4'b0001, 32'h101, '0, 5'd12, '0, '0, 0, 1'b0, '0, mk(5'd12, 32'd0, 1'b1, 1'b0));
    do_op("lwu",     4'b0110, 32'h100, '0, 5'd13, '0, '0, 0, 1'b0, '0, mk(5'd13, 32'd0, 1'b1, 1'b0));
    do_op("sbu",     4'b1100, 32'h100, '0, 5'd14, '0, '0, 0, 1'b0, '0, mk(5'd0,  32'd0, 1'b1, 1'b0));

    // Delayed grant with stable bus fields, then load timeout
    do_op("sw_gnt3", 4'b1010, 32'h2A4, 32'h0BAD_F00D, 5'd1, 4'hF, 32'h0BAD_F00D, 3, 1'b0, '0,
          mk(5'd0, 32'd0, 1'b0, 1'b0));
    do_op("lw_tmo",  4'b0010, 32'h2A8, '0, 5'd15, 4'hF, '0, 3, 1'b0, '0,
          mk(5'd15, 32'd0, 1'b0, 1'b1));

    // Reset while waiting for read data: op aborted, no response
    req_valid = 1'b1; mem_op = 4'b0010; addr = 32'h200; rd = 5'd7;
    step();
    req_valid = 1'b0; dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    nrst = 1'b0;
    #1;
    check("rst_wait/dmem_req",   {31'd0, dmem_req},   32'd0);
    check("rst_wait/resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_wait/req_ready",  {31'd0, req_ready},  32'd1);
    step();
    nrst = 1'b1;
    // Late rvalid arriving in IDLE must be ignored
    dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    step();
    check("stale_rv/resp_valid", {31'd0, resp_valid}, 32'd0);
    dmem_rvalid = 1'b0;
    step();
    check("stale_rv/resp_valid2", {31'd0, resp_valid}, 32'd0);

    // Reset while the request is on the bus drops dmem_req at once
    req_valid = 1'b1; mem_op = 4'b1010; addr = 32'h300; wdata = 32'h1;
    step();
    req_valid = 1'b0;
    check("rst_req/dmem_req_on", {31'd0, dmem_req}, 32'd1);
    nrst = 1'b0;
    #1;
    check("rst_req/dmem_req_off", {31'd0, dmem_req}, 32'd0);
    step();
    nrst = 1'b1;
    step();

    do_op("lw_after", 4'b0010, 32'h310, '0, 5'd9, 4'hF, '0, 0, 1'b1, 32'hCAFE_F00D,
          mk(5'd9, 32'hCAFE_F00D, 1'b0, 1'b0));

    step(); step();
    check("sb_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
